// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master (fetch, load/store) arbiter onto one shared memory port,
// one access outstanding, load/store priority with fetch starvation guard. Rev 1.0
`default_nettype none

module mem_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        if_req_i,
   input  logic [31:0] if_addr_i,
   output logic        if_ready_o,
   output logic        if_rvalid_o,
   output logic [31:0] if_rdata_o,
   input  logic        ls_req_i,
   input  logic [31:0] ls_addr_i,
   input  logic [31:0] ls_wdata_i,
   input  logic [3:0]  ls_wen_i,
   output logic        ls_ready_o,
   output logic        ls_rvalid_o,
   output logic [31:0] ls_rdata_o,
   output logic        mem_req_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   output logic [3:0]  mem_wen_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i
);

   localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } state_e;

   state_e      state_q;
   logic        sel_q;        // access owner: 0 = fetch, 1 = load/store
   logic        lock_q;
   logic        lock_sel_q;
   logic [2:0]  cnt_q;
   logic [2:0]  cnt_d;
   logic        sel_d;
   logic        gnt;
   logic        rsp;

   // A pending, ungranted request pins the selection so the address stays stable.
   always_comb begin
      sel_d = ls_req_i && !(if_req_i && (cnt_q == LIMIT));
      if (lock_q) begin
         sel_d = lock_sel_q;
      end
   end

   assign mem_req_o  = rst_n && (state_q == S_IDLE) && (lock_q || if_req_i || ls_req_i);
   assign gnt        = mem_req_o && mem_gnt_i;
   assign rsp        = rst_n && (state_q == S_WAIT) && mem_rvalid_i;

   assign mem_addr_o  = sel_d ? ls_addr_i : if_addr_i;
   assign mem_wdata_o = sel_d ? ls_wdata_i : 32'h0;
   assign mem_wen_o   = sel_d ? ls_wen_i : 4'h0;

   assign if_ready_o  = gnt && !sel_d;
   assign ls_ready_o  = gnt && sel_d;
   assign if_rvalid_o = rsp && !sel_q;
   assign ls_rvalid_o = rsp && sel_q;
   assign if_rdata_o  = mem_rdata_i;
   assign ls_rdata_o  = mem_rdata_i;

   always_comb begin
      cnt_d = cnt_q;
      if (gnt) begin
         if (!sel_d) begin
            cnt_d = 3'd0;
         end else if (if_req_i && (cnt_q < LIMIT)) begin
            cnt_d = cnt_q + 3'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         sel_q      <= 1'b0;
         lock_q     <= 1'b0;
         lock_sel_q <= 1'b0;
         cnt_q      <= 3'd0;
      end else begin
         cnt_q <= cnt_d;
         case (state_q)
            S_IDLE: begin
               if (gnt) begin
                  state_q <= S_WAIT;
                  sel_q   <= sel_d;
                  lock_q  <= 1'b0;
               end else if (mem_req_o) begin
                  lock_q     <= 1'b1;
                  lock_sel_q <= sel_d;
               end
            end
            S_WAIT: begin
               if (mem_rvalid_i) begin
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire
